// File: rtl/qpsk_frame_pkg.sv
// Shared types and constants for the QPSK differential frame sequencer.
// Holds the FSM state enum, preamble dibits, default sync word, the LFSR
// taps/seed for the optional payload scrambler (QPSK_FRAME_SCRAMBLE_EN),
// and small helpers used by qpsk_diff_frame_ctrl.
package qpsk_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_PRE  = 3'd2,
        ST_SYNC = 3'd3,
        ST_PAY  = 3'd4
    } state_e;

    localparam logic [1:0]  PRE_DIBIT_A       = 2'b00;
    localparam logic [1:0]  PRE_DIBIT_B       = 2'b11;
    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hE5A3;

    // x^7 + x^4 + 1: feedback from bits 6 and 3
    localparam logic [6:0]  LFSR_TAPS = 7'b100_1000;
    localparam logic [6:0]  LFSR_SEED = 7'h7F;

    // Dibit idx of the sync word, idx 0 = bits [15:14]
    function automatic logic [1:0] sync_dibit(input logic [15:0] word, input logic [2:0] idx);
        logic [15:0] sh;
        sh = word << {idx, 1'b0};
        return sh[15:14];
    endfunction

    // One Fibonacci LFSR step; the new bit enters at bit 0
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sym_tick_gen.sv
// Symbol-rate divider.
// Ports: clk, rst (async active-low), clr_i (sync clear to 0), en_i (count
// enable), tick_c (combinational, high one cycle before the count reaches
// DIV-1 so a registered strobe downstream lines up with count == DIV-1).
module sym_tick_gen #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap counter 0..DIV-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = en_i && !clr_i && (cnt_q == CW'(DIV - 2));

endmodule

// File: rtl/qpsk_diff_frame_ctrl.sv
// Frame sequencer for the QPSK absolute-to-relative code converter.
// Per frame: one-cycle reference clear, PRE_LEN alternating preamble dibits,
// 8 sync-word dibits, then 4*PAY_LEN payload dibits from the byte stream.
// Ports: clk, rst (async active-low), start, din/din_valid/din_ready (byte
// input), ab/sym_en (dibit + strobe), ref_clr, busy, frame_done, underrun.
// All outputs are registered.
// Optional: define QPSK_FRAME_SCRAMBLE_EN to XOR payload dibits with an
// x^7+x^4+1 LFSR (seeded 7'h7F per frame, 2 steps per payload dibit).
module qpsk_diff_frame_ctrl
    import qpsk_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned PRE_LEN   = 16,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int unsigned PAY_LEN   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] ab,
    output logic       sym_en,
    output logic       ref_clr,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    state_e     state_q, state_d;
    logic [7:0] sym_cnt_q, sym_cnt_d;
    logic [1:0] dib_q, dib_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic [1:0] ab_q, ab_d;
    logic       sym_en_q, sym_en_d;
    logic       ref_clr_q, ref_clr_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       underrun_q, underrun_d;
    logic       din_ready_q, din_ready_d;

    logic       tick;
    logic       cnt_clr;
    logic       cnt_en;
    logic       accept;
    logic [7:0] pay_byte;
    logic       have_byte;
    logic [1:0] pay_mask;

`ifdef QPSK_FRAME_SCRAMBLE_EN
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] lfsr_s1, lfsr_s2;
`endif

    assign cnt_clr = (state_q == ST_IDLE) || (state_q == ST_CLR);
    assign cnt_en  = (state_q == ST_PRE) || (state_q == ST_SYNC) || (state_q == ST_PAY);
    assign accept  = din_valid && din_ready_q;

    sym_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tick_c (tick)
    );

    // Next-state and registered-output logic; decisions are made on tick so
    // the strobe registers into the count == CLK_DIV-1 cycle.
    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        dib_d        = dib_q;
        byte_cnt_d   = byte_cnt_q;
        sr_d         = sr_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        ab_d         = ab_q;
        sym_en_d     = 1'b0;
        ref_clr_d    = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        pay_byte     = sr_q;
        have_byte    = 1'b0;
`ifdef QPSK_FRAME_SCRAMBLE_EN
        lfsr_d   = lfsr_q;
        lfsr_s1  = lfsr_step(lfsr_q);
        lfsr_s2  = lfsr_step(lfsr_s1);
        pay_mask = {lfsr_s1[0], lfsr_s2[0]};
`else
        pay_mask = 2'b00;
`endif

        if (accept) begin
            buf_d      = din;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLR;
                    ref_clr_d = 1'b1;
                end
            end
            ST_CLR: begin
                sym_cnt_d  = '0;
                dib_d      = '0;
                byte_cnt_d = '0;
                state_d    = ST_PRE;
`ifdef QPSK_FRAME_SCRAMBLE_EN
                lfsr_d     = LFSR_SEED;
`endif
            end
            ST_PRE: begin
                if (tick) begin
                    sym_en_d = 1'b1;
                    ab_d     = sym_cnt_q[0] ? PRE_DIBIT_B : PRE_DIBIT_A;
                    if (sym_cnt_q == 8'(PRE_LEN - 1)) begin
                        sym_cnt_d = '0;
                        state_d   = ST_SYNC;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (tick) begin
                    sym_en_d = 1'b1;
                    ab_d     = sync_dibit(SYNC_WORD, sym_cnt_q[2:0]);
                    if (sym_cnt_q[2:0] == 3'd7) begin
                        sym_cnt_d = '0;
                        state_d   = ST_PAY;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                    end
                end
            end
            ST_PAY: begin
                // Stay one extra cycle so frame_done and start can't overlap IDLE
                if (frame_done_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    sym_en_d = 1'b1;
                    if (dib_q != 2'd0) begin
                        have_byte = 1'b1;
                    end else if (buf_full_q) begin
                        pay_byte   = buf_q;
                        have_byte  = 1'b1;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        // Bypass: incoming byte goes straight to the shifter
                        pay_byte   = din;
                        have_byte  = 1'b1;
                        buf_full_d = 1'b0;
                    end

                    if (have_byte) begin
                        ab_d  = pay_byte[7:6] ^ pay_mask;
                        sr_d  = {pay_byte[5:0], 2'b00};
                        dib_d = dib_q + 2'd1;
`ifdef QPSK_FRAME_SCRAMBLE_EN
                        lfsr_d = lfsr_s2;
`endif
                        if (dib_q == 2'd3) begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            if (byte_cnt_q == 8'(PAY_LEN - 1)) begin
                                frame_done_d = 1'b1;
                            end
                        end
                    end else begin
                        // No data: send a filler dibit, hold all counters
                        ab_d       = 2'b00;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        din_ready_d = ((state_d == ST_SYNC) || (state_d == ST_PAY)) && !buf_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= '0;
            dib_q        <= '0;
            byte_cnt_q   <= '0;
            sr_q         <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            ab_q         <= '0;
            sym_en_q     <= 1'b0;
            ref_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            din_ready_q  <= 1'b0;
`ifdef QPSK_FRAME_SCRAMBLE_EN
            lfsr_q       <= LFSR_SEED;
`endif
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            dib_q        <= dib_d;
            byte_cnt_q   <= byte_cnt_d;
            sr_q         <= sr_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            ab_q         <= ab_d;
            sym_en_q     <= sym_en_d;
            ref_clr_q    <= ref_clr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            din_ready_q  <= din_ready_d;
`ifdef QPSK_FRAME_SCRAMBLE_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign din_ready  = din_ready_q;
    assign ab         = ab_q;
    assign sym_en     = sym_en_q;
    assign ref_clr    = ref_clr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_qpsk_diff_frame_ctrl.sv
// Scoreboard bench for qpsk_diff_frame_ctrl (CLK_DIV=8, PRE_LEN=4, PAY_LEN=2).
// Expected symbols are queued when a frame is requested; the monitor pops
// one entry on every sym_en and compares ab/underrun/frame_done.
module tb_qpsk_diff_frame_ctrl;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned PRE_LEN = 4;
    localparam int unsigned PAY_LEN = 2;

    typedef struct packed {
        logic [1:0] ab;
        logic       und;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] ab;
    logic       sym_en;
    logic       ref_clr;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    qpsk_diff_frame_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .PRE_LEN   (PRE_LEN),
        .SYNC_WORD (16'hE5A3),
        .PAY_LEN   (PAY_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .ab         (ab),
        .sym_en     (sym_en),
        .ref_clr    (ref_clr),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    int         ncyc = 0, last_ev = 0, clr_cyc = 0;
    int         frame_syms = 0, done_cnt = 0, clr_cnt = 0, exp_clr = 0, done_delta = 0;
    logic       feed_en;
    exp_t       mon_e;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

`ifdef QPSK_FRAME_SCRAMBLE_EN
    logic [6:0] m_lfsr;
    function automatic logic [1:0] scr_mask();
        logic b1, b2;
        b1 = m_lfsr[6] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[5:0], b1};
        b2 = m_lfsr[6] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[5:0], b2};
        return {b1, b2};
    endfunction
`endif

    function automatic logic [1:0] pay_dibit(input logic [1:0] d);
`ifdef QPSK_FRAME_SCRAMBLE_EN
        return d ^ scr_mask();
`else
        return d;
`endif
    endfunction

    // Build the expected symbol list of one frame, nu underruns at first payload symbol
    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input int nu);
        exp_t       e;
        logic [15:0] sw;
        logic [7:0]  b;
        sw = 16'hE5A3;
`ifdef QPSK_FRAME_SCRAMBLE_EN
        m_lfsr = 7'h7F;
`endif
        for (int i = 0; i < int'(PRE_LEN); i++) begin
            e.ab = (i % 2 == 1) ? 2'b11 : 2'b00; e.und = 1'b0; e.done = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            e.ab = sw[15-2*k -: 2]; e.und = 1'b0; e.done = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < nu; k++) begin
            e.ab = 2'b00; e.und = 1'b1; e.done = 1'b0;
            exp_q.push_back(e);
        end
        for (int j = 0; j < 2; j++) begin
            b = (j == 0) ? b0 : b1;
            for (int k = 0; k < 4; k++) begin
                e.ab = pay_dibit(b[7-2*k -: 2]); e.und = 1'b0;
                e.done = (j == 1 && k == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin got = 1; break; end
        end
        check("frame_done_seen", got, 1);
    endtask

    task automatic wait_syms(input int n, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (frame_syms >= n) begin got = 1; break; end
        end
        check("sym_count_reached", got, 1);
    endtask

    // Upstream byte source; acceptance sampled away from the edge
    initial begin
        logic acc;
        forever begin
            @(negedge clk);
            acc = din_valid && din_ready;
            @(posedge clk);
            #1;
            if (acc && src_q.size() > 0) void'(src_q.pop_front());
            din_valid = feed_en && (src_q.size() > 0);
            din       = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            if (ref_clr) begin
                clr_cnt++; clr_cyc = ncyc; last_ev = ncyc; frame_syms = 0;
            end
            if (sym_en) begin
                check("sym_spacing", ncyc - last_ev, int'(CLK_DIV));
                last_ev = ncyc;
                frame_syms++;
                check("sb_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("ab", int'(ab), int'(mon_e.ab));
                    check("underrun", int'(underrun), int'(mon_e.und));
                    check("frame_done", int'(frame_done), int'(mon_e.done));
                end
            end else begin
                check("no_stray_flags", int'({underrun, frame_done}), 0);
            end
            if (frame_done) begin
                done_cnt++;
                done_delta = ncyc - clr_cyc;
            end
        end
    end

    logic [1:0] nom [20] = '{2'b00, 2'b11, 2'b00, 2'b11,
                             2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11,
                             2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        int   n;
        exp_t e;
        rst = 1'b0; start = 1'b0; feed_en = 1'b0; din = 8'h00; din_valid = 1'b0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", int'({din_ready, ab, sym_en, ref_clr, busy, frame_done, underrun}), 0);
        rst = 1'b1;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sym_en) n++;
        end
        check("idle_no_sym", n, 0);
        check("idle_outputs", int'({din_ready, ab, sym_en, ref_clr, busy, frame_done, underrun}), 0);

        // Nominal frame, hand-written symbol list
`ifdef QPSK_FRAME_SCRAMBLE_EN
        m_lfsr = 7'h7F;
`endif
        for (int i = 0; i < 20; i++) begin
            e.ab = (i >= 12) ? pay_dibit(nom[i]) : nom[i];
            e.und = 1'b0; e.done = (i == 19);
            exp_q.push_back(e);
        end
        src_q.push_back(8'hC6); src_q.push_back(8'h1B);
        feed_en = 1'b1;
        exp_clr++; do_start();
        check("busy_in_frame", int'(busy), 1);
        wait_done(400);
        @(posedge clk); #1;
        check("nominal_done_latency", done_delta, 160);
        repeat (2) @(posedge clk); #1;
        check("idle_after_frame", int'(busy), 0);

        // Underrun on first payload symbol
        feed_en = 1'b0;
        push_frame(8'hC6, 8'h1B, 1);
        src_q.push_back(8'hC6); src_q.push_back(8'h1B);
        exp_clr++; do_start();
        wait_syms(13, 400);
        #1 feed_en = 1'b1;
        wait_done(400);
        @(posedge clk); #1;
        check("underrun_done_latency", done_delta, 168);

        // start while busy and in the frame_done cycle
        push_frame(8'hA5, 8'h3C, 0);
        src_q.push_back(8'hA5); src_q.push_back(8'h3C);
        exp_clr++; do_start();
        wait_syms(14, 400);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk); #1;
        check("start_ignored_busy", int'(busy), 0);
        check("ref_clr_count", clr_cnt, exp_clr);
        check("done_count_3", done_cnt, 3);

        // Reset mid-SYNC, then a full frame
        push_frame(8'h11, 8'h22, 0);
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        exp_clr++; do_start();
        wait_syms(6, 400);
        #3 rst = 1'b0;
        #1 check("async_reset_outputs", int'({din_ready, ab, sym_en, ref_clr, busy, frame_done, underrun}), 0);
        exp_q.delete(); src_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("no_done_on_reset", done_cnt, 3);
        push_frame(8'h5A, 8'hF0, 0);
        src_q.push_back(8'h5A); src_q.push_back(8'hF0);
        exp_clr++; do_start();
        wait_done(400);
        @(posedge clk); #1;
        check("post_reset_done_latency", done_delta, 160);

        repeat (10) @(posedge clk); #1;
        check("done_count_final", done_cnt, 4);
        check("ref_clr_count_final", clr_cnt, exp_clr);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
